// File: rtl/tap_pkg.sv
// tap_pkg -- shared types for the TAP controller slice.
//   tap_state_t      : 4-bit state enum; the code values are the pad-visible
//                      observation encoding and must not change.
//   TAP_RESET_STATE  : state entered on TRST (Test-Logic-Reset).
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_TLR    = 4'hF,
    TAP_RTI    = 4'hC,
    TAP_SEL_DR = 4'h7,
    TAP_CAP_DR = 4'h6,
    TAP_SH_DR  = 4'h2,
    TAP_EX1_DR = 4'h1,
    TAP_PAU_DR = 4'h3,
    TAP_EX2_DR = 4'h0,
    TAP_UPD_DR = 4'h5,
    TAP_SEL_IR = 4'h4,
    TAP_CAP_IR = 4'hE,
    TAP_SH_IR  = 4'hA,
    TAP_EX1_IR = 4'h9,
    TAP_PAU_IR = 4'hB,
    TAP_EX2_IR = 4'h8,
    TAP_UPD_IR = 4'hD
  } tap_state_t;

  localparam tap_state_t TAP_RESET_STATE = TAP_TLR;

endpackage

// File: rtl/tap_next_state.sv
// tap_next_state -- combinational IEEE 1149.1 TAP transition function.
// Ports:
//   state : current TAP state
//   tms   : TMS value sampled on the coming rising edge
//   next  : state to load on that edge (reset priority handled by caller)
module tap_next_state
  import tap_pkg::*;
(
  input  tap_state_t state,
  input  logic       tms,
  output tap_state_t next
);

  always_comb begin
    next = TAP_RESET_STATE;
    unique case (state)
      TAP_TLR:    next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: next = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: next = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: next = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: next = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: next = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: next = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: next = tms ? TAP_SEL_DR : TAP_RTI;
      default:    next = TAP_RESET_STATE;
    endcase
  end

endmodule

// File: rtl/tap_half_fsm.sv
// tap_half_fsm -- IEEE 1149.1 TAP controller state register with pad-level
// state observation.
// Ports:
//   GCLK_Pad        : test clock, rising-edge active
//   TRST_Pad        : synchronous active-high reset to Test-Logic-Reset
//   TMS_Pad         : test mode select
//   state_obs3..0   : current state code, driven straight from the register
// Optional (macro TAP_DECODE_EN): registered one-hot state decodes
//   tlr_o, rti_o, capture_dr_o, shift_dr_o, update_dr_o,
//   capture_ir_o, shift_ir_o, update_ir_o
module tap_half_fsm
  import tap_pkg::*;
(
  input  logic GCLK_Pad,
  input  logic TRST_Pad,
  input  logic TMS_Pad,
`ifdef TAP_DECODE_EN
  output logic tlr_o,
  output logic rti_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o,
`endif
  output logic state_obs0_Pad,
  output logic state_obs1_Pad,
  output logic state_obs2_Pad,
  output logic state_obs3_Pad
);

  tap_state_t state_q;
  tap_state_t state_n;

  tap_next_state u_next (
    .state (state_q),
    .tms   (TMS_Pad),
    .next  (state_n)
  );

`ifdef TAP_DECODE_EN
  // Decodes are computed from the state being loaded (reset applied) so they
  // land on the same edge as state_obs while still coming from flops.
  tap_state_t state_load;

  always_comb begin
    state_load = TRST_Pad ? TAP_RESET_STATE : state_n;
  end

  always_ff @(posedge GCLK_Pad) begin
    state_q      <= state_load;
    tlr_o        <= (state_load == TAP_TLR);
    rti_o        <= (state_load == TAP_RTI);
    capture_dr_o <= (state_load == TAP_CAP_DR);
    shift_dr_o   <= (state_load == TAP_SH_DR);
    update_dr_o  <= (state_load == TAP_UPD_DR);
    capture_ir_o <= (state_load == TAP_CAP_IR);
    shift_ir_o   <= (state_load == TAP_SH_IR);
    update_ir_o  <= (state_load == TAP_UPD_IR);
  end
`else
  always_ff @(posedge GCLK_Pad) begin
    if (TRST_Pad) state_q <= TAP_RESET_STATE;
    else          state_q <= state_n;
  end
`endif

  assign state_obs0_Pad = state_q[0];
  assign state_obs1_Pad = state_q[1];
  assign state_obs2_Pad = state_q[2];
  assign state_obs3_Pad = state_q[3];

endmodule

// File: tb/tb_tap_half_fsm.sv
// tb_tap_half_fsm -- self-checking bench for tap_half_fsm.
// Directed vector table plus random TMS/TRST traffic against a table-lookup
// reference model; decode outputs are also checked when TAP_DECODE_EN is set.
module tb_tap_half_fsm;

  logic clk = 1'b0;
  logic trst = 1'b1;
  logic tms = 1'b0;
  logic o0, o1, o2, o3;
  logic [3:0] obs;
`ifdef TAP_DECODE_EN
  logic d_tlr, d_rti, d_cdr, d_sdr, d_udr, d_cir, d_sir, d_uir;
`endif

  assign obs = {o3, o2, o1, o0};

  always #5 clk = ~clk;

  tap_half_fsm dut (
    .GCLK_Pad       (clk),
    .TRST_Pad       (trst),
    .TMS_Pad        (tms),
`ifdef TAP_DECODE_EN
    .tlr_o          (d_tlr),
    .rti_o          (d_rti),
    .capture_dr_o   (d_cdr),
    .shift_dr_o     (d_sdr),
    .update_dr_o    (d_udr),
    .capture_ir_o   (d_cir),
    .shift_ir_o     (d_sir),
    .update_ir_o    (d_uir),
`endif
    .state_obs0_Pad (o0),
    .state_obs1_Pad (o1),
    .state_obs2_Pad (o2),
    .state_obs3_Pad (o3)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: transition tables indexed by state code.
  int n0 [16];
  int n1 [16];
  int mstate = 15;

  typedef struct {
    logic       r;
    logic       m;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic m);
    trst = r;
    tms  = m;
    @(posedge clk);
    #1;
    if (r) mstate = 15;
    else   mstate = m ? n1[mstate] : n0[mstate];
    check("obs_model", {4'h0, obs}, 8'(mstate));
`ifdef TAP_DECODE_EN
    check("decode",
          {d_tlr, d_rti, d_cdr, d_sdr, d_udr, d_cir, d_sir, d_uir},
          {mstate == 15, mstate == 12, mstate == 6, mstate == 2,
           mstate == 5, mstate == 14, mstate == 10, mstate == 13});
`endif
  endtask

  function automatic vec_t v(input logic r, input logic m, input logic [3:0] e);
    vec_t x;
    x.r = r; x.m = m; x.exp = e;
    return x;
  endfunction

  initial begin
    // state:           0  1  2  3  4   5  6  7  8   9  A   B  C  D   E  F
    n0 = '{ 2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    n1 = '{ 5, 5, 1, 0, 15,  7, 1, 4, 13, 13,  9,  8,  7,  7,  9, 15};

    // reset then RTI
    vecs.push_back(v(1, 0, 4'hF));
    vecs.push_back(v(0, 0, 4'hC));
    // from TLR: 1,0,0,1,0 then reset with TMS=1
    vecs.push_back(v(1, 0, 4'hF));
    vecs.push_back(v(0, 1, 4'hF));
    vecs.push_back(v(0, 0, 4'hC));
    vecs.push_back(v(0, 0, 4'hC));
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 0, 4'h6));
    vecs.push_back(v(1, 1, 4'hF));
    // to RTI, then DR path
    vecs.push_back(v(0, 0, 4'hC));
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 0, 4'h6));
    vecs.push_back(v(0, 0, 4'h2));
    vecs.push_back(v(0, 0, 4'h2));
    vecs.push_back(v(0, 1, 4'h1));
    vecs.push_back(v(0, 0, 4'h3));
    vecs.push_back(v(0, 1, 4'h0));
    vecs.push_back(v(0, 1, 4'h5));
    vecs.push_back(v(0, 0, 4'hC));
    // IR path
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 1, 4'h4));
    vecs.push_back(v(0, 0, 4'hE));
    vecs.push_back(v(0, 0, 4'hA));
    vecs.push_back(v(0, 1, 4'h9));
    vecs.push_back(v(0, 0, 4'hB));
    vecs.push_back(v(0, 1, 4'h8));
    vecs.push_back(v(0, 1, 4'hD));
    vecs.push_back(v(0, 1, 4'h7));
    // back into ShIR, then five TMS=1 edges and a sixth
    vecs.push_back(v(0, 1, 4'h4));
    vecs.push_back(v(0, 0, 4'hE));
    vecs.push_back(v(0, 0, 4'hA));
    vecs.push_back(v(0, 1, 4'h9));
    vecs.push_back(v(0, 1, 4'hD));
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 1, 4'h4));
    vecs.push_back(v(0, 1, 4'hF));
    vecs.push_back(v(0, 1, 4'hF));
    // reset mid-shift (ShDR) and from pause (PauIR)
    vecs.push_back(v(0, 0, 4'hC));
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 0, 4'h6));
    vecs.push_back(v(0, 0, 4'h2));
    vecs.push_back(v(1, 0, 4'hF));
    vecs.push_back(v(0, 0, 4'hC));
    vecs.push_back(v(0, 1, 4'h7));
    vecs.push_back(v(0, 1, 4'h4));
    vecs.push_back(v(0, 0, 4'hE));
    vecs.push_back(v(0, 1, 4'h9));
    vecs.push_back(v(0, 0, 4'hB));
    vecs.push_back(v(1, 0, 4'hF));

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].m);
      check($sformatf("vec%0d", i), {4'h0, obs}, {4'h0, vecs[i].exp});
    end

    // Random traffic, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom));
    end

    // Five TMS=1 edges from wherever a random walk lands must reach TLR.
    for (int t = 0; t < 40; t++) begin
      int steps;
      steps = $urandom_range(1, 12);
      for (int k = 0; k < steps; k++) step(1'b0, 1'($urandom));
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
      check("five_tms_tlr", {4'h0, obs}, 8'h0F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
